// File: rtl/debug_controller.sv
// UART debug controller: loads instruction memory, runs/steps the pipeline and dumps PC, registers and data memory.
// Optional feature: define DEBUG_CHECKSUM_EN to append an XOR checksum byte after each dump.
module debug_controller #(
    parameter int NB_DATA    = 32,
    parameter int N_BITS     = 8,
    parameter int NB_IM_ADDR = 8,
    parameter int NB_REG     = 5,
    parameter int N_REGS     = 32,
    parameter int NB_DM_ADDR = 5,
    parameter int N_DM_WORDS = 32,
    parameter int NB_STATE   = 10
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [N_BITS-1:0]     i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_tx_done,
    input  logic                  i_halt,
    input  logic [NB_DATA-1:0]    i_pc_value,
    input  logic [NB_DATA-1:0]    i_br_data,
    input  logic [NB_DATA-1:0]    i_dm_data,
    output logic                  o_im_write_enable,
    output logic [NB_DATA-1:0]    o_im_data_write,
    output logic [NB_IM_ADDR-1:0] o_im_addr,
    output logic [N_BITS-1:0]     o_tx_data,
    output logic                  o_tx_start,
    output logic [NB_REG-1:0]     o_br_addr,
    output logic [NB_DM_ADDR-1:0] o_dm_addr,
    output logic                  o_dm_read_enable,
    output logic                  o_enable_pipe,
    output logic                  o_debug_unit_load,
    output logic [NB_STATE-1:0]   o_state
);

    localparam int BPW         = NB_DATA / N_BITS;
    localparam int NB_BYTE_IDX = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int NB_CNT      = N_BITS + 1;

    localparam logic [NB_BYTE_IDX-1:0] LAST_BYTE = NB_BYTE_IDX'(BPW - 1);
    localparam logic [NB_REG-1:0]      LAST_REG  = NB_REG'(N_REGS - 1);
    localparam logic [NB_DM_ADDR-1:0]  LAST_DM   = NB_DM_ADDR'(N_DM_WORDS - 1);

    localparam logic [N_BITS-1:0] CMD_LOAD = N_BITS'(8'h4C);
    localparam logic [N_BITS-1:0] CMD_CONT = N_BITS'(8'h43);
    localparam logic [N_BITS-1:0] CMD_STEP = N_BITS'(8'h53);
    localparam logic [N_BITS-1:0] CMD_DUMP = N_BITS'(8'h44);

    typedef enum logic [NB_STATE-1:0] {
        IDLE       = NB_STATE'(1 << 0),
        LOAD_CNT   = NB_STATE'(1 << 1),
        LOAD_BYTE  = NB_STATE'(1 << 2),
        LOAD_WRITE = NB_STATE'(1 << 3),
        RUN        = NB_STATE'(1 << 4),
        STEP       = NB_STATE'(1 << 5),
        DUMP_PC    = NB_STATE'(1 << 6),
        DUMP_REG   = NB_STATE'(1 << 7),
        DUMP_MEM   = NB_STATE'(1 << 8),
        TX_WAIT    = NB_STATE'(1 << 9)
    } state_t;

    typedef enum logic [1:0] {SEL_PC, SEL_REG, SEL_MEM, SEL_CSUM} dump_sel_t;

    state_t                 state;
    dump_sel_t              dump_sel;
    logic [NB_CNT-1:0]      word_count;
    logic [NB_CNT-1:0]      words_done;
    logic [NB_BYTE_IDX-1:0] byte_idx;
    logic [NB_DATA-1:0]     shift;
    logic                   fetched;
    logic [N_BITS-1:0]      csum;

    // Bytes arrive LSB first, so each new byte enters at the top and the word slides down.
    logic [NB_DATA-1:0] load_next;
    logic [NB_DATA-1:0] shift_next;
    assign load_next  = NB_DATA'({i_rx_data, o_im_data_write} >> N_BITS);
    assign shift_next = shift >> N_BITS;

    assign o_state = state;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state             <= IDLE;
            dump_sel          <= SEL_PC;
            word_count        <= '0;
            words_done        <= '0;
            byte_idx          <= '0;
            shift             <= '0;
            fetched           <= 1'b0;
            csum              <= '0;
            o_im_write_enable <= 1'b0;
            o_im_data_write   <= '0;
            o_im_addr         <= '0;
            o_tx_data         <= '0;
            o_tx_start        <= 1'b0;
            o_br_addr         <= '0;
            o_dm_addr         <= '0;
            o_dm_read_enable  <= 1'b0;
            o_enable_pipe     <= 1'b0;
            o_debug_unit_load <= 1'b0;
        end else begin
            // NOTE: later non-blocking assignments override these defaults within the same cycle.
            o_im_write_enable <= 1'b0;
            o_tx_start        <= 1'b0;
            o_debug_unit_load <= 1'b1;

            case (state)
                IDLE: begin
                    if (i_rx_done) begin
                        case (i_rx_data)
                            CMD_LOAD: state <= LOAD_CNT;
                            CMD_CONT, CMD_STEP: begin
                                state             <= (i_rx_data == CMD_CONT) ? RUN : STEP;
                                o_enable_pipe     <= ~i_halt;
                                o_debug_unit_load <= 1'b0;
                            end
                            CMD_DUMP: state <= DUMP_PC;
                            default: ;
                        endcase
                    end
                end

                LOAD_CNT: begin
                    if (i_rx_done) begin
                        word_count <= (i_rx_data == '0) ? NB_CNT'(1 << N_BITS) : {1'b0, i_rx_data};
                        words_done <= '0;
                        byte_idx   <= '0;
                        o_im_addr  <= '0;
                        state      <= LOAD_BYTE;
                    end
                end

                LOAD_BYTE: begin
                    if (i_rx_done) begin
                        o_im_data_write <= load_next;
                        if (byte_idx == LAST_BYTE) begin
                            byte_idx          <= '0;
                            o_im_write_enable <= 1'b1;
                            state             <= LOAD_WRITE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end

                LOAD_WRITE: begin
                    o_im_addr  <= o_im_addr + 1'b1;
                    words_done <= words_done + 1'b1;
                    state      <= (words_done + 1'b1 == word_count) ? IDLE : LOAD_BYTE;
                end

                RUN: begin
                    if (i_halt) begin
                        o_enable_pipe <= 1'b0;
                        state         <= DUMP_PC;
                    end else begin
                        o_enable_pipe     <= 1'b1;
                        o_debug_unit_load <= 1'b0;
                    end
                end

                STEP: begin
                    o_enable_pipe <= 1'b0;
                    state         <= DUMP_PC;
                end

                DUMP_PC: begin
                    shift      <= i_pc_value;
                    o_tx_data  <= i_pc_value[N_BITS-1:0];
                    o_tx_start <= 1'b1;
                    byte_idx   <= '0;
                    csum       <= '0;
                    dump_sel   <= SEL_PC;
                    state      <= TX_WAIT;
                end

                // Memory reads are synchronous: wait one cycle after the address before capturing.
                DUMP_REG, DUMP_MEM: begin
                    if (!fetched) begin
                        fetched <= 1'b1;
                    end else begin
                        fetched    <= 1'b0;
                        shift      <= (state == DUMP_REG) ? i_br_data : i_dm_data;
                        o_tx_data  <= (state == DUMP_REG) ? i_br_data[N_BITS-1:0] : i_dm_data[N_BITS-1:0];
                        o_tx_start <= 1'b1;
                        byte_idx   <= '0;
                        dump_sel   <= (state == DUMP_REG) ? SEL_REG : SEL_MEM;
                        state      <= TX_WAIT;
                    end
                end

                TX_WAIT: begin
                    if (i_tx_done) begin
                        csum <= csum ^ o_tx_data;
                        if (dump_sel == SEL_CSUM) begin
                            state <= IDLE;
                        end else if (byte_idx != LAST_BYTE) begin
                            byte_idx   <= byte_idx + 1'b1;
                            shift      <= shift_next;
                            o_tx_data  <= shift_next[N_BITS-1:0];
                            o_tx_start <= 1'b1;
                        end else begin
                            case (dump_sel)
                                SEL_PC: begin
                                    o_br_addr <= '0;
                                    state     <= DUMP_REG;
                                end
                                SEL_REG: begin
                                    if (o_br_addr == LAST_REG) begin
                                        o_dm_addr        <= '0;
                                        o_dm_read_enable <= 1'b1;
                                        state            <= DUMP_MEM;
                                    end else begin
                                        o_br_addr <= o_br_addr + 1'b1;
                                        state     <= DUMP_REG;
                                    end
                                end
                                default: begin
                                    if (o_dm_addr == LAST_DM) begin
                                        o_dm_read_enable <= 1'b0;
`ifdef DEBUG_CHECKSUM_EN
                                        o_tx_data  <= csum ^ o_tx_data;
                                        o_tx_start <= 1'b1;
                                        dump_sel   <= SEL_CSUM;
`else
                                        state <= IDLE;
`endif
                                    end else begin
                                        o_dm_addr <= o_dm_addr + 1'b1;
                                        state     <= DUMP_MEM;
                                    end
                                end
                            endcase
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_controller.sv
// Directed self-checking bench for debug_controller: load, step, run, dump handshake, reset abort, ignored commands.
module tb_debug_controller;

    localparam int NB_DATA = 32;
    localparam int N_BITS = 8;
    localparam int NB_IM_ADDR = 8;
    localparam int NB_REG = 5;
    localparam int N_REGS = 32;
    localparam int NB_DM_ADDR = 5;
    localparam int N_DM_WORDS = 32;
    localparam int NB_STATE = 10;
`ifdef DEBUG_CHECKSUM_EN
    localparam int DUMP_LEN = 261;
`else
    localparam int DUMP_LEN = 260;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_BITS-1:0]     rx_data;
    logic                  rx_done;
    logic                  tx_done;
    logic                  halt;
    logic [NB_DATA-1:0]    pc_value;
    logic [NB_DATA-1:0]    br_data;
    logic [NB_DATA-1:0]    dm_data;
    logic                  im_we;
    logic [NB_DATA-1:0]    im_data;
    logic [NB_IM_ADDR-1:0] im_addr;
    logic [N_BITS-1:0]     tx_data;
    logic                  tx_start;
    logic [NB_REG-1:0]     br_addr;
    logic [NB_DM_ADDR-1:0] dm_addr;
    logic                  dm_re;
    logic                  en_pipe;
    logic                  du_load;
    logic [NB_STATE-1:0]   state;

    debug_controller #(
        .NB_DATA(NB_DATA), .N_BITS(N_BITS), .NB_IM_ADDR(NB_IM_ADDR), .NB_REG(NB_REG),
        .N_REGS(N_REGS), .NB_DM_ADDR(NB_DM_ADDR), .N_DM_WORDS(N_DM_WORDS), .NB_STATE(NB_STATE)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_tx_done(tx_done), .i_halt(halt), .i_pc_value(pc_value), .i_br_data(br_data),
        .i_dm_data(dm_data), .o_im_write_enable(im_we), .o_im_data_write(im_data),
        .o_im_addr(im_addr), .o_tx_data(tx_data), .o_tx_start(tx_start), .o_br_addr(br_addr),
        .o_dm_addr(dm_addr), .o_dm_read_enable(dm_re), .o_enable_pipe(en_pipe),
        .o_debug_unit_load(du_load), .o_state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_word(input int a);
        return 32'hA500_0000 + 32'(a) * 32'h0001_0101;
    endfunction

    function automatic logic [31:0] mem_word(input int a);
        return 32'h5A00_0000 + 32'(a) * 32'h0102_0003;
    endfunction

    // Synchronous memory models: data one cycle after the address.
    always @(posedge clk) begin
        br_data <= reg_word(int'(br_addr));
        dm_data <= mem_word(int'(dm_addr));
    end

    int en_total = 0;
    int we_total = 0;
    logic [31:0] we_data_log [0:15];
    logic [7:0]  we_addr_log [0:15];

    always @(negedge clk) begin
        if (en_pipe === 1'b1) en_total++;
        if (im_we === 1'b1) begin
            if (we_total < 16) begin
                we_data_log[we_total] = im_data;
                we_addr_log[we_total] = im_addr;
            end
            we_total++;
        end
    end

    int passed = 0;
    int failed = 0;
    int total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    logic [7:0] dump_buf [0:299];
    int dump_n, hold_err, extra_start;

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic collect_dump(input int delay);
        int waited;
        logic [7:0] held;
        dump_n = 0;
        hold_err = 0;
        extra_start = 0;
        for (int b = 0; b < 300; b++) begin
            waited = 0;
            while (tx_start !== 1'b1 && waited < 12) begin
                @(negedge clk);
                waited++;
            end
            if (tx_start !== 1'b1) break;
            held = tx_data;
            dump_buf[dump_n] = held;
            dump_n++;
            @(negedge clk);
            for (int d = 0; d < delay; d++) begin
                if (tx_data !== held) hold_err++;
                if (tx_start !== 1'b0) extra_start++;
                @(negedge clk);
            end
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    endtask

    function automatic logic [31:0] dump_word(input int k);
        return {dump_buf[4*k+3], dump_buf[4*k+2], dump_buf[4*k+1], dump_buf[4*k]};
    endfunction

    task automatic check_dump(input string tag, input logic [31:0] pc);
        logic [7:0] x;
        check({tag, "_len"}, 32'(dump_n), 32'(DUMP_LEN));
        check({tag, "_pc"}, dump_word(0), pc);
        check({tag, "_reg0"}, dump_word(1), reg_word(0));
        check({tag, "_reg31"}, dump_word(32), reg_word(31));
        check({tag, "_mem0"}, dump_word(33), mem_word(0));
        check({tag, "_mem31"}, dump_word(64), mem_word(31));
`ifdef DEBUG_CHECKSUM_EN
        x = '0;
        for (int i = 0; i < 260; i++) x ^= dump_buf[i];
        check({tag, "_csum"}, 32'(dump_buf[260]), 32'(x));
`else
        x = '0;
`endif
        check({tag, "_idle"}, 32'(state), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, w0, cnt;
        rst = 1'b1;
        rx_data = '0;
        rx_done = 1'b0;
        tx_done = 1'b0;
        halt = 1'b0;
        pc_value = 32'h0040_0010;
        repeat (3) @(negedge clk);

        check("rst_state", 32'(state), 32'd1);
        check("rst_we", 32'(im_we), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_en", 32'(en_pipe), 32'd0);
        check("rst_du_load", 32'(du_load), 32'd0);
        check("rst_im_addr", 32'(im_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_du_load", 32'(du_load), 32'd1);

        // Two-word load.
        w0 = we_total;
        send_byte(8'h4C);
        send_byte(8'h02);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
        check("load_no_early_we", 32'(im_we), 32'd0);
        send_byte(8'h12);
        check("load_we0_timing", 32'(im_we), 32'd1);
        check("load_we0_data", im_data, 32'h1234_5678);
        check("load_we0_addr", 32'(im_addr), 32'd0);
        @(negedge clk);
        send_byte(8'hEF); @(negedge clk);
        send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        check("load_write_state", 32'(state), 32'h008);
        repeat (2) @(negedge clk);
        check("load_back_idle", 32'(state), 32'd1);
        check("load_we_count", 32'(we_total - w0), 32'd2);
        check("load_w1_data", we_data_log[w0 + 1], 32'hDEAD_BEEF);
        check("load_w1_addr", 32'(we_addr_log[w0 + 1]), 32'd1);

        // Unknown command is ignored.
        send_byte(8'h58);
        check("unknown_state", 32'(state), 32'd1);
        repeat (4) @(negedge clk);
        check("unknown_no_tx", 32'(tx_start), 32'd0);
        check("unknown_still_idle", 32'(state), 32'd1);

        // Single step with the pipeline running.
        e0 = en_total;
        send_byte(8'h53);
        check("step_en_first", 32'(en_pipe), 32'd1);
        check("step_du_load", 32'(du_load), 32'd0);
        collect_dump(0);
        check("step_en_cycles", 32'(en_total - e0), 32'd1);
        check_dump("step", 32'h0040_0010);

        // Continuous run halted after 17 enable cycles.
        pc_value = 32'h0000_0144;
        e0 = en_total;
        send_byte(8'h43);
        check("run_en_first", 32'(en_pipe), 32'd1);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (en_pipe === 1'b1) cnt++;
            if (cnt == 17) break;
            @(negedge clk);
        end
        halt = 1'b1;
        collect_dump(0);
        check("run_en_cycles", 32'(en_total - e0), 32'd17);
        check_dump("run", 32'h0000_0144);

        // Step while already halted: dump only.
        e0 = en_total;
        send_byte(8'h53);
        collect_dump(0);
        check("halted_step_en", 32'(en_total - e0), 32'd0);
        check("halted_step_len", 32'(dump_n), 32'(DUMP_LEN));
        halt = 1'b0;

        // Slow transmitter: data held, no early start pulse.
        pc_value = 32'h89AB_CDEF;
        send_byte(8'h44);
        collect_dump(50);
        check("slow_hold_err", 32'(hold_err), 32'd0);
        check("slow_extra_start", 32'(extra_start), 32'd0);
        check_dump("slow", 32'h89AB_CDEF);

        // Reset in the middle of a load.
        w0 = we_total;
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", 32'(state), 32'd1);
        check("abort_partial", im_data, 32'd0);
        check("abort_addr", 32'(im_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        repeat (2) @(negedge clk);
        check("reload_we_count", 32'(we_total - w0), 32'd1);
        check("reload_addr", 32'(we_addr_log[w0]), 32'd0);
        check("reload_data", we_data_log[w0], 32'h4433_2211);
        check("reload_idle", 32'(state), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/debug_controller.md
# debug_controller

Parametrised UART debug controller for the MIPS pipeline; successor to the fixed 32-bit debug unit. Decodes single-byte host commands, assembles bytes into instruction words and loads instruction memory, runs the pipeline continuously or one cycle at a time, and streams PC, register file and a configurable data-memory window back to the host. Sits between the UART rx/tx and the pipeline debug ports in the debug top level.

## Interface
- NB_DATA, 32, datapath word width; multiple of N_BITS
- N_BITS, 8, UART byte width
- NB_IM_ADDR, 8, instruction-memory word-address width
- NB_REG, 5, register-file address width
- N_REGS, 32, registers dumped, 1..2^NB_REG
- NB_DM_ADDR, 5, data-memory word-address width
- N_DM_WORDS, 32, data words dumped, 1..2^NB_DM_ADDR
- NB_STATE, 10, one-hot state width
- i_clock  in  1  single clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  N_BITS  received byte, valid when i_rx_done
- i_rx_done  in  1  one-cycle rx strobe
- i_tx_done  in  1  one-cycle strobe: transmitter finished current byte
- i_halt  in  1  pipeline executed HALT
- i_pc_value  in  NB_DATA  current PC
- i_br_data  in  NB_DATA  register read data, valid 1 cycle after o_br_addr
- i_dm_data  in  NB_DATA  data-memory read data, valid 1 cycle after o_dm_addr
- o_im_write_enable  out  1  one-cycle instruction write strobe
- o_im_data_write  out  NB_DATA  assembled instruction word
- o_im_addr  out  NB_IM_ADDR  instruction write address
- o_tx_data  out  N_BITS  byte to send
- o_tx_start  out  1  one-cycle tx start pulse
- o_br_addr  out  NB_REG  register dump address
- o_dm_addr  out  NB_DM_ADDR  data dump address
- o_dm_read_enable  out  1  high during data-memory dump
- o_enable_pipe  out  1  pipeline clock enable
- o_debug_unit_load  out  1  pipeline memory ports driven by this block
- o_state  out  NB_STATE  one-hot current state

## Operation
- BPW = NB_DATA/N_BITS bytes per word, LSB byte first, both directions.
- States (bit index): IDLE0, LOAD_CNT1, LOAD_BYTE2, LOAD_WRITE3, RUN4, STEP5, DUMP_PC6, DUMP_REG7, DUMP_MEM8, TX_WAIT9.
- IDLE: on i_rx_done, byte 0x4C 'L' -> LOAD_CNT; 0x43 'C' -> RUN; 0x53 'S' -> STEP; 0x44 'D' -> DUMP_PC; other bytes ignored.
- LOAD_CNT: next byte = word count N (0 means 256); im address cleared to 0 -> LOAD_BYTE.
- LOAD_BYTE: shift in BPW bytes; after last -> LOAD_WRITE: o_im_write_enable high exactly one cycle, address then increments (wraps modulo 2^NB_IM_ADDR); after N words -> IDLE, else LOAD_BYTE.
- RUN: o_enable_pipe high every cycle until cycle i_halt seen high, then low -> DUMP_PC. Already halted on entry: zero enable cycles.
- STEP: o_enable_pipe high exactly one cycle (none if i_halt) -> DUMP_PC.
- Dump order: PC (BPW bytes), registers 0..N_REGS-1, data words 0..N_DM_WORDS-1; then IDLE. Word captured into shift register one cycle after address set; each byte goes through TX_WAIT.
- o_debug_unit_load high in all states except RUN and STEP.
- rx bytes outside IDLE/LOAD_CNT/LOAD_BYTE ignored.

## Timing
- Reset: state IDLE, all outputs 0 (o_state = 1), counters and im address 0. Reset mid-operation aborts load/run/dump on that edge; partial word discarded.
- o_tx_start: one-cycle pulse, o_tx_data stable from pulse until i_tx_done; next pulse no earlier than the cycle after i_tx_done.
- o_im_write_enable asserted one cycle after the last byte's i_rx_done, data/address stable that cycle.
- Command byte -> first o_enable_pipe cycle: 1 cycle. i_halt high -> o_enable_pipe low next edge.
- Simultaneous i_rx_done and i_tx_done: tx handled, rx dropped (dump states only).

## Configuration
- DEBUG_CHECKSUM_EN defined: after the last dump byte, one extra byte = XOR of all dump bytes, sent via same handshake, then IDLE. Undefined: no checksum byte, IDLE after last data byte; dump length = BPW*(1+N_REGS+N_DM_WORDS).

## Test plan
- Reset then 'L',0x02, bytes 78 56 34 12 EF BE AD DE -> writes 0x12345678 at addr 0, 0xDEADBEEF at addr 1, one strobe each, back to IDLE.
- 'S' with i_halt=0 -> exactly one o_enable_pipe cycle, then 4+128+128 = 260 bytes (261 with DEBUG_CHECKSUM_EN); first 4 bytes = i_pc_value LSB first.
- 'C', i_halt raised after 17 enable cycles -> exactly 17 enable cycles, then dump.
- i_tx_done delayed 50 cycles per byte -> o_tx_data held, no second o_tx_start before i_tx_done.
- Reset asserted mid-load after 3 bytes -> IDLE next cycle, no write strobe; new 'L' restarts at address 0.
- Unknown byte 0x58 in IDLE, and 'S' while i_halt=1 -> no state change; zero enable cycles, dump only.
